// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp encoding and default timing for the traffic lamp driver.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    EW_GREEN  = 3'd1,
    EW_YELLOW = 3'd2,
    NS_GREEN  = 3'd3,
    NS_YELLOW = 3'd4
  } state_t;

  // One-hot lamp word ordered {Red, Yellow, Green}
  typedef logic [2:0] lamp_t;
  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  localparam int DEF_MIN_GREEN_CYCLES = 5;
  localparam int DEF_YELLOW_CYCLES    = 3;
  localparam int DEF_ALLRED_CYCLES    = 2;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable saturating down-counter timing each lamp phase; expired when it reaches zero.
module traffic_phase_timer #(
  parameter int            W           = 1,
  parameter logic [W-1:0]  RESET_VALUE = '0
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/traffic_lamp_driver.sv
// Turns the controller's per-direction go requests into safe lamp drive with
// minimum green, fixed yellow and all-red clearance, and flags conflicting requests.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
  parameter int YELLOW_CYCLES    = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES    = DEF_ALLRED_CYCLES
) (
  input  logic Clock,
  input  logic Reset,
  input  logic EWLite,
  input  logic NSLite,
  output logic EWRed,
  output logic EWYellow,
  output logic EWGreen,
  output logic NSRed,
  output logic NSYellow,
  output logic NSGreen,
  output logic Conflict
);

  localparam int TW = timer_width(MIN_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
  localparam logic [TW-1:0] GREEN_LOAD  = TW'(MIN_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_CYCLES - 1);

  state_t        state, state_next;
  logic          load;
  logic [TW-1:0] load_value;
  logic          expired;
  logic          conflict;
  lamp_t         ew_lamp, ns_lamp;

  traffic_phase_timer #(
    .W           (TW),
    .RESET_VALUE (ALLRED_LOAD)
  ) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (load),
    .load_value (load_value),
    .expired    (expired)
  );

  assign conflict = EWLite & NSLite;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ALL_RED;
      Conflict <= 1'b0;
    end else begin
      state    <= state_next;
      Conflict <= conflict;
    end
  end

  // A conflict cuts a green short; otherwise green holds until min time and request drop
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_value = ALLRED_LOAD;
    case (state)
      ALL_RED: begin
        if (expired && EWLite && !NSLite) begin
          state_next = EW_GREEN;
          load       = 1'b1;
          load_value = GREEN_LOAD;
        end else if (expired && NSLite && !EWLite) begin
          state_next = NS_GREEN;
          load       = 1'b1;
          load_value = GREEN_LOAD;
        end
      end
      EW_GREEN: begin
        if (conflict || (expired && !EWLite)) begin
          state_next = EW_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_LOAD;
        end
      end
      NS_GREEN: begin
        if (conflict || (expired && !NSLite)) begin
          state_next = NS_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_LOAD;
        end
      end
      EW_YELLOW, NS_YELLOW: begin
        if (expired) begin
          state_next = ALL_RED;
          load       = 1'b1;
          load_value = ALLRED_LOAD;
        end
      end
      default: begin
        state_next = ALL_RED;
        load       = 1'b1;
        load_value = ALLRED_LOAD;
      end
    endcase
  end

  always_comb begin
    ew_lamp = LAMP_RED;
    ns_lamp = LAMP_RED;
    case (state)
      EW_GREEN:  ew_lamp = LAMP_GREEN;
      EW_YELLOW: ew_lamp = LAMP_YELLOW;
      NS_GREEN:  ns_lamp = LAMP_GREEN;
      NS_YELLOW: ns_lamp = LAMP_YELLOW;
      default: begin
        ew_lamp = LAMP_RED;
        ns_lamp = LAMP_RED;
      end
    endcase
  end

  assign {EWRed, EWYellow, EWGreen} = ew_lamp;
  assign {NSRed, NSYellow, NSGreen} = ns_lamp;

endmodule
